// File: rtl/ram_arbiter.sv
// Two-port RAM arbiter: CPU read/write vs. screen-fetch read, 1-cycle RAM latency.
// Optional screen starvation guard enabled with `define ARB_STARVE_GUARD_EN.
module ram_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  CLK_50,
  input  logic                  resetN,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  scr_req,
  input  logic [ADDR_WIDTH-1:0] scr_addr,
  output logic                  scr_gnt,
  output logic                  scr_rvalid,
  output logic [DATA_WIDTH-1:0] scr_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_CPU = 2'd1,
    RD_SCR = 2'd2
  } state_e;

  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("MAX_WAIT must be at least 1");
  end

  state_e                  state_q, state_d;
  logic                    run_q, run_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_WIDTH-1:0]   scr_rdata_q, scr_rdata_d;
  logic                    force_scr;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WMAX = CW'(MAX_WAIT);

  logic [CW-1:0] cnt_q, cnt_d;

  assign force_scr = scr_req && (cnt_q == WMAX);

  always_comb begin
    cnt_d = cnt_q;
    if (!scr_req || scr_gnt) begin
      cnt_d = '0;
    end else if (cnt_q != WMAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign force_scr = 1'b0;
`endif

  // run_q keeps grants low while reset is held, without using resetN as data
  assign run_d = 1'b1;

  assign cpu_gnt = run_q & cpu_req & ~force_scr;
  assign scr_gnt = run_q & scr_req & (~cpu_req | force_scr);

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (1'b1)
      cpu_gnt: begin
        addr_d  = cpu_addr;
        wdata_d = cpu_wdata;
      end
      scr_gnt: addr_d = scr_addr;
      default: ;
    endcase
  end

  assign ram_addr  = addr_d;
  assign ram_wdata = wdata_d;
  assign ram_we    = cpu_gnt & cpu_we;

  always_comb begin
    state_d = IDLE;
    unique case (1'b1)
      cpu_gnt & ~cpu_we: state_d = RD_CPU;
      scr_gnt:           state_d = RD_SCR;
      default:           state_d = IDLE;
    endcase
  end

  assign cpu_rvalid = (state_q == RD_CPU);
  assign scr_rvalid = (state_q == RD_SCR);

  // rdata follows the RAM while valid and holds the last valid word otherwise
  always_comb begin
    cpu_rdata_d = cpu_rdata_q;
    scr_rdata_d = scr_rdata_q;
    if (cpu_rvalid) begin
      cpu_rdata_d = ram_rdata;
    end
    if (scr_rvalid) begin
      scr_rdata_d = ram_rdata;
    end
  end

  assign cpu_rdata = cpu_rdata_d;
  assign scr_rdata = scr_rdata_d;

  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      run_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      scr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      scr_rdata_q <= scr_rdata_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: grants checked per cycle,
// read returns queued at issue and popped by a monitor.
module tb_ram_arbiter;

  logic        CLK_50 = 1'b0;
  logic        resetN;
  logic        cpu_req, cpu_we;
  logic [11:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        scr_req;
  logic [11:0] scr_addr;
  logic        scr_gnt, scr_rvalid;
  logic [15:0] scr_rdata;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;

  logic [15:0] mem [0:4095];
  logic [16:0] sb [$];
  logic [11:0] last_addr;
  int n_vec = 0;
  int n_bad = 0;

  ram_arbiter #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(12),
    .MAX_WAIT(4)
  ) dut (
    .CLK_50    (CLK_50),
    .resetN    (resetN),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata (cpu_rdata),
    .scr_req   (scr_req),
    .scr_addr  (scr_addr),
    .scr_gnt   (scr_gnt),
    .scr_rvalid(scr_rvalid),
    .scr_rdata (scr_rdata),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #10 CLK_50 = ~CLK_50;

  always @(posedge CLK_50) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: pops one expected return per rvalid
  always @(negedge CLK_50) begin
    if (resetN) begin
      if (cpu_rvalid && scr_rvalid) begin
        chk("both_rvalid", {cpu_rvalid, scr_rvalid}, 32'h1);
      end else if (cpu_rvalid || scr_rvalid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rvalid", {cpu_rvalid, scr_rvalid}, 32'h0);
        end else begin
          logic [16:0] e;
          e = sb.pop_front();
          chk("rvalid_port", {31'd0, scr_rvalid}, {31'd0, e[16]});
          chk("rdata", scr_rvalid ? scr_rdata : cpu_rdata, e[15:0]);
        end
      end
    end
  end

  task automatic step(input logic cr, input logic cwe,
                      input logic [11:0] ca, input logic [15:0] cwd,
                      input logic sr, input logic [11:0] sa,
                      input logic ecg, input logic esg,
                      input logic [15:0] ed, input string nm);
    logic [11:0] ea;
    @(posedge CLK_50);
    #1;
    cpu_req = cr; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cwd;
    scr_req = sr; scr_addr = sa;
    @(negedge CLK_50);
    chk({nm, ".cpu_gnt"}, cpu_gnt, ecg);
    chk({nm, ".scr_gnt"}, scr_gnt, esg);
    ea = ecg ? ca : (esg ? sa : last_addr);
    chk({nm, ".ram_addr"}, ram_addr, ea);
    last_addr = ea;
    chk({nm, ".ram_we"}, ram_we, ecg & cwe);
    if (ecg && cwe) chk({nm, ".ram_wdata"}, ram_wdata, cwd);
    if ((ecg && !cwe) || esg) sb.push_back({esg, ed});
  endtask

  task automatic idle(input string nm);
    step(0, 0, 12'h000, 16'h0000, 0, 12'h000, 0, 0, 16'h0, nm);
  endtask

  task automatic check_rst(input string nm);
    chk({nm, ".cpu_gnt"}, cpu_gnt, 0);
    chk({nm, ".scr_gnt"}, scr_gnt, 0);
    chk({nm, ".cpu_rvalid"}, cpu_rvalid, 0);
    chk({nm, ".scr_rvalid"}, scr_rvalid, 0);
    chk({nm, ".ram_we"}, ram_we, 0);
    chk({nm, ".ram_addr"}, ram_addr, 0);
    chk({nm, ".ram_wdata"}, ram_wdata, 0);
    chk({nm, ".cpu_rdata"}, cpu_rdata, 0);
    chk({nm, ".scr_rdata"}, scr_rdata, 0);
  endtask

  initial begin
    logic ecg, esg;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[12'h010] = 16'h1234;
    mem[12'h011] = 16'h2222;
    mem[12'h012] = 16'h3333;
    mem[12'h020] = 16'h5555;
    mem[12'h030] = 16'hAAAA;
    last_addr = 12'h000;

    resetN = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h123;
    cpu_wdata = 16'hFFFF; scr_req = 1'b1; scr_addr = 12'h321;
    repeat (2) @(negedge CLK_50);
    check_rst("por");
    cpu_req = 0; cpu_we = 0; scr_req = 0;
    resetN = 1'b1;

    step(1, 0, 12'h010, 16'h0, 0, 12'h000, 1, 0, 16'h1234, "cpu_rd");
    idle("idle1");

    step(1, 0, 12'h020, 16'h0, 1, 12'h030, 1, 0, 16'h5555, "both");
    idle("idle2");

    step(1, 0, 12'h010, 16'h0, 0, 12'h000, 1, 0, 16'h1234, "b2b0");
    step(1, 0, 12'h011, 16'h0, 0, 12'h000, 1, 0, 16'h2222, "b2b1");
    step(0, 0, 12'h000, 16'h0, 1, 12'h012, 0, 1, 16'h3333, "b2b2");
    step(1, 0, 12'h020, 16'h0, 0, 12'h000, 1, 0, 16'h5555, "b2b3");
    idle("idle3");

    step(1, 1, 12'h7FF, 16'hBEEF, 0, 12'h000, 1, 0, 16'h0, "wr");
    step(0, 0, 12'h000, 16'h0, 1, 12'h7FF, 0, 1, 16'hBEEF, "scr_rd");
    idle("idle4");

    for (int i = 0; i < 8; i++) begin
`ifdef ARB_STARVE_GUARD_EN
      esg = (i == 4);
`else
      esg = 1'b0;
`endif
      ecg = !esg;
      step(1, 0, 12'h020, 16'h0, 1, 12'h030, ecg, esg,
           esg ? 16'hAAAA : 16'h5555, $sformatf("starve%0d", i));
    end
    idle("idle5");
    idle("idle6");

    step(1, 0, 12'h011, 16'h0, 0, 12'h000, 1, 0, 16'h2222, "pre_rst");
    void'(sb.pop_back());
    @(posedge CLK_50);
    #2;
    resetN = 1'b0;
    cpu_req = 1; scr_req = 1;
    @(negedge CLK_50);
    check_rst("mid_rd_rst");
    cpu_req = 0; scr_req = 0;
    resetN = 1'b1;
    last_addr = 12'h000;
    idle("post_rst0");
    idle("post_rst1");
    idle("post_rst2");

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, meaning the word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 12, meaning the RAM address width.
REQ-003 The block SHALL have parameter MAX_WAIT, default 4, meaning the number of consecutive denied screen-request cycles before the screen is forced to win.
REQ-004 Port CLK_50 SHALL be: input, 1 bit, sole clock, rising edge.
REQ-005 Port resetN SHALL be: input, 1 bit, reset, asynchronous, active-low.
REQ-006 Port cpu_req SHALL be: input, 1 bit, CPU requests an access this cycle.
REQ-007 Port cpu_we SHALL be: input, 1 bit, CPU access is a write.
REQ-008 Port cpu_addr SHALL be: input, ADDR_WIDTH bits, CPU address.
REQ-009 Port cpu_wdata SHALL be: input, DATA_WIDTH bits, CPU write data.
REQ-010 Port cpu_gnt SHALL be: output, 1 bit, CPU access issued this cycle.
REQ-011 Port cpu_rvalid SHALL be: output, 1 bit, CPU read data valid.
REQ-012 Port cpu_rdata SHALL be: output, DATA_WIDTH bits, CPU read data.
REQ-013 Port scr_req SHALL be: input, 1 bit, screen-fetch read request.
REQ-014 Port scr_addr SHALL be: input, ADDR_WIDTH bits, screen word address.
REQ-015 Port scr_gnt SHALL be: output, 1 bit, screen read issued this cycle.
REQ-016 Port scr_rvalid SHALL be: output, 1 bit, screen read data valid.
REQ-017 Port scr_rdata SHALL be: output, DATA_WIDTH bits, screen read data.
REQ-018 Port ram_addr SHALL be: output, ADDR_WIDTH bits, RAM address.
REQ-019 Port ram_we SHALL be: output, 1 bit, RAM write enable.
REQ-020 Port ram_wdata SHALL be: output, DATA_WIDTH bits, RAM write data.
REQ-021 Port ram_rdata SHALL be: input, DATA_WIDTH bits, RAM read data, valid one cycle after the address is presented.

Function
REQ-022 At most one of cpu_gnt and scr_gnt SHALL be high in any cycle; each grant is combinational from the same-cycle requests and the registered state.
REQ-023 With no forced screen win, cpu_req SHALL win; scr_gnt = scr_req & ~cpu_req.
REQ-024 The granted requester's address, plus the CPU's we and wdata, SHALL drive ram_*; ram_we SHALL be high only on cpu_gnt & cpu_we; with no grant, ram_we = 0 and ram_addr holds its previous value.
REQ-025 A 2-bit return FSM SHALL have states IDLE, RD_CPU and RD_SCR; the next state is RD_CPU on a CPU read grant, RD_SCR on a screen grant, and IDLE otherwise.
REQ-026 In RD_CPU, cpu_rvalid = 1 and cpu_rdata = ram_rdata; in RD_SCR, scr_rvalid = 1 and scr_rdata = ram_rdata; the read latency is exactly 1 cycle after the grant.
REQ-027 rvalid outputs SHALL be low in all other states; rdata outputs hold their last valid value.
REQ-028 A CPU write SHALL produce no rvalid.
REQ-029 Back-to-back grants SHALL be sustained with one access per cycle and no bubble.
REQ-030 The starvation counter SHALL be $clog2(MAX_WAIT+1) bits; it increments when scr_req & ~scr_gnt, saturates at MAX_WAIT, and clears on scr_gnt or when scr_req is low.
REQ-031 When counter == MAX_WAIT and scr_req = 1, the screen SHALL win and cpu_gnt = 0 that cycle; the CPU retries with its request held.

Reset
REQ-032 While resetN = 0: all grant and rvalid outputs = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0, rdata outputs = 0, FSM = IDLE, counter = 0.
REQ-033 Reset asserted with a read in flight SHALL drop that read; no rvalid is produced after reset is released.

Configuration
REQ-034 With macro ARB_STARVE_GUARD_EN defined, REQ-030 and REQ-031 SHALL apply.
REQ-035 Without ARB_STARVE_GUARD_EN, no counter SHALL exist and strict CPU priority SHALL apply.

Verification
REQ-036 Reset: assert resetN = 0 mid-read -> all outputs 0, and no rvalid appears after release.
REQ-037 CPU read: addr 0x010 with RAM content 0x1234 -> cpu_gnt in cycle N, cpu_rvalid with 0x1234 in cycle N+1.
REQ-038 Simultaneous requests: cpu_req and scr_req both high for 1 cycle -> cpu_gnt = 1, scr_gnt = 0, counter = 1.
REQ-039 Starvation: cpu_req and scr_req held high with MAX_WAIT = 4 -> scr_gnt on the 5th cycle, with cpu_gnt = 0 in that cycle; without the macro, scr_gnt is never asserted.
REQ-040 Write then read: CPU writes 0xBEEF to 0x7FF, then the screen reads 0x7FF -> ram_we pulses for one cycle, and scr_rvalid returns 0xBEEF with cpu_rvalid staying 0.
